// File: rtl/rom_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rom_loader_if                                                |
// | Description : Load-stream and read-port bundle for rom_loader. The master  |
// |               modport is the boot/config source plus the read consumer;    |
// |               the slave modport is the loader itself.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface rom_loader_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  // Burst control
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  // Write stream
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  // Status
  logic              busy;
  logic              done;
  logic              err;
  // Read port
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  modport master (
    output start, base_addr, len, wr_valid, wr_data, addr,
    input  wr_ready, busy, done, err, data
  );

  modport slave (
    input  start, base_addr, len, wr_valid, wr_data, addr,
    output wr_ready, busy, done, err, data
  );
endinterface
`default_nettype wire

// File: rtl/rom_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rom_loader                                                   |
// | Description : Loads a DEPTH x DATA_W array from a valid/ready byte stream  |
// |               in bursts (base address + length), and serves registered    |
// |               reads on an addr/data port in every state.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rom_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2**ADDR_W
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  rom_loader_if.slave  bus
);

  // len is one bit wider than the address so that a full-array burst fits.
  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] c_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] c_ZERO  = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_remaining;
  logic              r_err;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_len_ok;
  logic w_xfer;
  logic w_go;
  logic w_reject;

  assign w_len_ok = (bus.len != c_ZERO) && (bus.len <= c_DEPTH);
  assign w_xfer   = (r_state == S_LOAD) && bus.wr_valid;
  assign w_go     = (r_state == S_IDLE) && bus.start && w_len_ok;

  // Next-state logic; any start that does not launch a burst is flagged as rejected.
  always_comb begin
    w_state_nxt = r_state;
    w_reject    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_len_ok) w_state_nxt = S_LOAD;
          else          w_reject    = 1'b1;
        end
      end
      S_LOAD: begin
        w_reject = bus.start;
        if (w_xfer && (r_remaining == c_ONE)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        // A start seen here is dropped; if it is still held next cycle,
        // IDLE evaluates it afresh.
        w_reject    = bus.start;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Burst pointer and word countdown; pointer wraps naturally at ADDR_W bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_remaining <= '0;
    end else if (w_go) begin
      r_ptr       <= bus.base_addr;
      r_remaining <= bus.len;
    end else if (w_xfer) begin
      r_ptr       <= r_ptr + 1'b1;
      r_remaining <= r_remaining - c_ONE;
    end
  end

  // Error pulse lands in the cycle after the rejected start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_reject;
  end

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_xfer) r_mem[r_ptr] <= bus.wr_data;
  end

  // Registered read; sampling the array before this edge's write gives read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_data <= '0;
    else        r_data <= r_mem[bus.addr];
  end

  assign bus.wr_ready = (r_state == S_LOAD);
  assign bus.busy     = (r_state == S_LOAD);
  assign bus.done     = (r_state == S_DONE);
  assign bus.err      = r_err;
  assign bus.data     = r_data;

endmodule
`default_nettype wire
